// File: rtl/dp_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dp_mem_responder
// Description : Arbitrates datapath fetch and data requests onto one RAM port
//               and returns single-cycle hit pulses with registered load data.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_mem_responder #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        halted,
    output logic        bus_err,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready
);

    typedef enum logic [2:0] {
        c_IDLE = 3'd0,
        c_DACC = 3'd1,
        c_IACC = 3'd2,
        c_DONE = 3'd3,
        c_HALT = 3'd4
    } state_t;

    localparam logic [15:0] c_CNT_LAST = 16'(TIMEOUT - 1);

    state_t      r_state_q, w_state_d;
    logic [15:0] r_cnt_q, w_cnt_d;
    logic        r_ifetch_q, w_ifetch_d;
    logic [31:0] r_imemload_q, w_imemload_d;
    logic [31:0] r_dmemload_q, w_dmemload_d;
    logic        r_bus_err_q, w_bus_err_d;

    logic w_dreq;
    logic w_dread;
    logic w_timeout;
    logic w_unused_addr_bits;

    assign w_dreq             = dmemREN | dmemWEN;
    assign w_dread            = dmemREN & ~dmemWEN;
    assign w_timeout          = (r_cnt_q == c_CNT_LAST);
    assign w_unused_addr_bits = ^{imemaddr[1:0], dmemaddr[1:0]};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state_q    <= c_IDLE;
            r_cnt_q      <= '0;
            r_ifetch_q   <= 1'b0;
            r_imemload_q <= '0;
            r_dmemload_q <= '0;
            r_bus_err_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_ifetch_q   <= w_ifetch_d;
            r_imemload_q <= w_imemload_d;
            r_dmemload_q <= w_dmemload_d;
            r_bus_err_q  <= w_bus_err_d;
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_ifetch_d   = r_ifetch_q;
        w_imemload_d = r_imemload_q;
        w_dmemload_d = r_dmemload_q;
        w_bus_err_d  = r_bus_err_q;
        case (r_state_q)
            c_IDLE: begin
                w_cnt_d = '0;
                // Data wins a tie with fetch; a pending data access is also served before halting.
                if (w_dreq) begin
                    w_state_d  = c_DACC;
                    w_ifetch_d = 1'b0;
                end else if (imemREN && !halt) begin
                    w_state_d  = c_IACC;
                    w_ifetch_d = 1'b1;
                end else if (halt) begin
                    w_state_d = c_HALT;
                end
            end
            c_DACC: begin
                if (!w_dreq) begin
                    w_state_d = c_IDLE;
                end else if (ram_ready || w_timeout) begin
                    w_state_d = c_DONE;
                    if (!ram_ready) w_bus_err_d = 1'b1;
                    if (w_dread)    w_dmemload_d = ram_ready ? ramload : ERR_WORD;
                end else begin
                    w_cnt_d = r_cnt_q + 16'd1;
                end
            end
            c_IACC: begin
                if (!imemREN) begin
                    w_state_d = c_IDLE;
                end else if (ram_ready || w_timeout) begin
                    w_state_d    = c_DONE;
                    w_imemload_d = ram_ready ? ramload : ERR_WORD;
                    if (!ram_ready) w_bus_err_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + 16'd1;
                end
            end
            c_DONE:  w_state_d = c_IDLE;
            c_HALT:  w_state_d = c_HALT;
            default: w_state_d = c_IDLE;
        endcase
    end

    // Strobes follow the live request so a withdrawn access drops them immediately.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state_q)
            c_DACC: begin
                ramREN   = w_dread;
                ramWEN   = dmemWEN;
                ramaddr  = {dmemaddr[31:2], 2'b00};
                ramstore = dmemstore;
            end
            c_IACC: begin
                ramREN  = imemREN;
                ramaddr = {imemaddr[31:2], 2'b00};
            end
            default: ;
        endcase
    end

    assign ihit     = (r_state_q == c_DONE) &  r_ifetch_q;
    assign dhit     = (r_state_q == c_DONE) & ~r_ifetch_q;
    assign halted   = (r_state_q == c_HALT);
    assign bus_err  = r_bus_err_q;
    assign imemload = r_imemload_q;
    assign dmemload = r_dmemload_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_mem_responder
// Description : Directed and randomized checks of dp_mem_responder against a
//               transaction-level reference model and a wait-state RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_mem_responder;
    localparam int unsigned c_TIMEOUT  = 4;
    localparam logic [31:0] c_ERR_WORD = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN, dmemREN, dmemWEN, halt;
    logic [31:0] imemaddr, dmemaddr, dmemstore;
    logic        ihit, dhit, halted, bus_err, ramREN, ramWEN;
    logic [31:0] imemload, dmemload, ramaddr, ramstore;
    logic        ram_ready = 1'b0;
    logic [31:0] ramload   = 32'h0;

    int checks   = 0;
    int failures = 0;

    dp_mem_responder #(.TIMEOUT(c_TIMEOUT), .ERR_WORD(c_ERR_WORD)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .halt(halt), .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
        .halted(halted), .bus_err(bus_err), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    // RAM device: ready after dev_wait stalled cycles of a held strobe, never if stuck.
    logic [31:0] dev_mem [logic [31:0]];
    int dev_wait  = 0;
    bit dev_stuck = 1'b0;
    int dev_cnt   = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    always @(negedge CLK) begin
        ram_ready = (ramREN || ramWEN) && !dev_stuck && (dev_cnt >= dev_wait);
        ramload   = 32'h0;
        if (ramREN && ram_ready)
            ramload = dev_mem.exists(ramaddr) ? dev_mem[ramaddr] : init_word(ramaddr);
    end

    always @(posedge CLK) begin
        if (ram_ready && ramWEN) dev_mem[ramaddr] = ramstore;
        if ((ramREN || ramWEN) && !ram_ready) dev_cnt = dev_cnt + 1;
        else dev_cnt = 0;
    end

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_imemload = 32'h0;
    logic [31:0] exp_dmemload = 32'h0;
    bit          exp_bus_err  = 1'b0;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle_inputs();
        dev_stuck = 1'b0; dev_wait = 0;
        step(); step();
        nRST = 1'b1;
        exp_imemload = 32'h0; exp_dmemload = 32'h0; exp_bus_err = 1'b0;
        step();
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        imemREN = 1'b1; dmemWEN = 1'b1; halt = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            checks++;
            if ({ihit, dhit, halted, bus_err, ramREN, ramWEN} !== 6'b0) begin
                failures++;
                $display("FAIL reset_flags c=%0d got=%b exp=000000", c,
                         {ihit, dhit, halted, bus_err, ramREN, ramWEN});
            end
            checks++;
            if (imemload !== 32'h0 || dmemload !== 32'h0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
                failures++;
                $display("FAIL reset_data got=%h/%h/%h/%h exp=0", imemload, dmemload, ramaddr, ramstore);
            end
            step();
        end
        idle_inputs();
        nRST = 1'b1;
        step();
    endtask

    task automatic test_zero_wait_fetch();
        dev_stuck = 1'b0; dev_wait = 0;
        dev_mem[32'h4] = 32'h3C010004;
        ref_mem[32'h4] = 32'h3C010004;
        imemREN = 1'b1; imemaddr = 32'h6;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0) begin failures++; $display("FAIL zw_idle_strobe got=%b exp=0", ramREN); end
        step(); @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h4 || ihit !== 1'b0) begin
            failures++;
            $display("FAIL zw_cycle1 got ren=%b wen=%b addr=%h ihit=%b exp ren=1 wen=0 addr=00000004 ihit=0",
                     ramREN, ramWEN, ramaddr, ihit);
        end
        step(); @(negedge CLK);
        checks++;
        if (ihit !== 1'b1 || dhit !== 1'b0 || imemload !== 32'h3C010004) begin
            failures++;
            $display("FAIL zw_cycle2 got ihit=%b dhit=%b load=%h exp ihit=1 dhit=0 load=3c010004", ihit, dhit, imemload);
        end
        step();
        imemREN = 1'b0;
        exp_imemload = 32'h3C010004;
        @(negedge CLK);
        checks++;
        if (ihit !== 1'b0 || imemload !== exp_imemload) begin
            failures++;
            $display("FAIL zw_hold got ihit=%b load=%h exp ihit=0 load=%h", ihit, imemload, exp_imemload);
        end
        step();
    endtask

    task automatic test_simultaneous();
        int dgot, igot;
        bit both_hit;
        dev_stuck = 1'b0; dev_wait = 3;
        imemREN = 1'b1; imemaddr = 32'h200;
        dmemWEN = 1'b1; dmemaddr = 32'h100; dmemstore = 32'hDEADBEEF;
        dgot = -1; igot = -1; both_hit = 1'b0;
        for (int c = 0; c < 20 && igot < 0; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                checks++;
                if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF) begin
                    failures++;
                    $display("FAIL sim_data_strobe got wen=%b ren=%b addr=%h st=%h exp 1 0 00000100 deadbeef",
                             ramWEN, ramREN, ramaddr, ramstore);
                end
            end
            if (c == 7) begin
                checks++;
                if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h200) begin
                    failures++;
                    $display("FAIL sim_fetch_strobe got ren=%b wen=%b addr=%h exp 1 0 00000200", ramREN, ramWEN, ramaddr);
                end
            end
            if (ihit && dhit) both_hit = 1'b1;
            if (ihit && igot < 0) igot = c;
            if (dhit && dgot < 0) dgot = c;
            step();
            if (dgot == c) dmemWEN = 1'b0;
        end
        imemREN = 1'b0;
        ref_mem[32'h100] = 32'hDEADBEEF;
        exp_imemload = ref_read(32'h200);
        checks++;
        if (dgot !== 5) begin failures++; $display("FAIL sim_dhit_cycle got=%0d exp=5", dgot); end
        checks++;
        if (igot !== 11) begin failures++; $display("FAIL sim_ihit_cycle got=%0d exp=11", igot); end
        checks++;
        if (both_hit) begin failures++; $display("FAIL sim_both_hits got=1 exp=0"); end
        checks++;
        if (imemload !== exp_imemload || dmemload !== exp_dmemload) begin
            failures++;
            $display("FAIL sim_loads got=%h/%h exp=%h/%h", imemload, dmemload, exp_imemload, exp_dmemload);
        end
        checks++;
        if (!dev_mem.exists(32'h100) || dev_mem[32'h100] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sim_ram_write got=%h exp=deadbeef", dev_mem.exists(32'h100) ? dev_mem[32'h100] : 32'h0);
        end
    endtask

    task automatic test_withdrawal();
        bit any_hit;
        dev_stuck = 1'b1;
        dmemREN = 1'b1; dmemaddr = 32'h80;
        any_hit = 1'b0;
        step(); @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1) begin failures++; $display("FAIL wd_strobe_on got=%b exp=1", ramREN); end
        step();
        dmemREN = 1'b0;
        @(negedge CLK);
        any_hit = any_hit | dhit | ihit;
        checks++;
        if (ramREN !== 1'b0) begin failures++; $display("FAIL wd_strobe_drop got=%b exp=0", ramREN); end
        step();
        // A fresh request now must see IDLE first: no strobe this cycle, strobe next.
        dmemREN = 1'b1;
        @(negedge CLK);
        any_hit = any_hit | dhit | ihit;
        checks++;
        if (ramREN !== 1'b0) begin failures++; $display("FAIL wd_idle_next got ren=%b exp=0", ramREN); end
        step(); @(negedge CLK);
        any_hit = any_hit | dhit | ihit;
        checks++;
        if (ramREN !== 1'b1) begin failures++; $display("FAIL wd_restart got ren=%b exp=1", ramREN); end
        step();
        dmemREN = 1'b0;
        step();
        dev_stuck = 1'b0;
        checks++;
        if (any_hit) begin failures++; $display("FAIL wd_no_hit got=1 exp=0"); end
    endtask

    task automatic test_random();
        int kind, w, got, exp_lat;
        bit wrong, tmo, both;
        logic [31:0] addr, data, exp_addr;
        for (int n = 0; n < 40; n++) begin
            kind     = $urandom_range(0, 2);
            w        = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
            addr     = $urandom & 32'h3FF;
            data     = $urandom;
            both     = 1'($urandom_range(0, 1));
            exp_addr = addr & 32'hFFFF_FFFC;
            tmo      = (w >= int'(c_TIMEOUT));
            exp_lat  = 2 + (tmo ? int'(c_TIMEOUT) - 1 : w);
            dev_wait = w; dev_stuck = 1'b0;
            case (kind)
                0:       begin imemREN = 1'b1; imemaddr = addr; end
                1:       begin dmemREN = 1'b1; dmemaddr = addr; end
                default: begin dmemWEN = 1'b1; dmemREN = both; dmemaddr = addr; dmemstore = data; end
            endcase
            got = -1; wrong = 1'b0;
            for (int c = 0; c < 20 && got < 0; c++) begin
                @(negedge CLK);
                if (c == 1) begin
                    checks++;
                    if (ramaddr !== exp_addr || ramREN !== (kind != 2) || ramWEN !== (kind == 2) ||
                        (kind == 2 && ramstore !== data)) begin
                        failures++;
                        $display("FAIL rand_strobe n=%0d got ren=%b wen=%b addr=%h st=%h exp ren=%b wen=%b addr=%h",
                                 n, ramREN, ramWEN, ramaddr, ramstore, kind != 2, kind == 2, exp_addr);
                    end
                end
                if ((kind == 0 && dhit) || (kind != 0 && ihit)) wrong = 1'b1;
                if ((kind == 0 && ihit) || (kind != 0 && dhit)) got = c;
                step();
            end
            idle_inputs();
            case (kind)
                0:       exp_imemload = tmo ? c_ERR_WORD : ref_read(exp_addr);
                1:       exp_dmemload = tmo ? c_ERR_WORD : ref_read(exp_addr);
                default: if (!tmo) ref_mem[exp_addr] = data;
            endcase
            exp_bus_err = exp_bus_err | tmo;
            checks++;
            if (got !== exp_lat) begin
                failures++;
                $display("FAIL rand_latency n=%0d kind=%0d wait=%0d got=%0d exp=%0d", n, kind, w, got, exp_lat);
            end
            checks++;
            if (wrong) begin failures++; $display("FAIL rand_wrong_hit n=%0d got=1 exp=0", n); end
            checks++;
            if (imemload !== exp_imemload) begin
                failures++; $display("FAIL rand_imemload n=%0d got=%h exp=%h", n, imemload, exp_imemload);
            end
            checks++;
            if (dmemload !== exp_dmemload) begin
                failures++; $display("FAIL rand_dmemload n=%0d got=%h exp=%h", n, dmemload, exp_dmemload);
            end
            checks++;
            if (bus_err !== exp_bus_err) begin
                failures++; $display("FAIL rand_bus_err n=%0d got=%b exp=%b", n, bus_err, exp_bus_err);
            end
        end
        step();
    endtask

    task automatic test_timeout();
        int got;
        bit err_early;
        do_reset();
        checks++;
        if (bus_err !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", bus_err); end
        dev_stuck = 1'b1;
        dmemREN = 1'b1; dmemaddr = 32'h40;
        got = -1; err_early = 1'b0;
        for (int c = 0; c < 15 && got < 0; c++) begin
            @(negedge CLK);
            if (dhit) got = c;
            else if (bus_err) err_early = 1'b1;
            step();
        end
        dmemREN = 1'b0;
        exp_dmemload = c_ERR_WORD;
        checks++;
        if (got !== 5) begin failures++; $display("FAIL to_dhit_cycle got=%0d exp=5", got); end
        checks++;
        if (err_early) begin failures++; $display("FAIL to_err_early got=1 exp=0"); end
        checks++;
        if (dmemload !== c_ERR_WORD || bus_err !== 1'b1) begin
            failures++; $display("FAIL to_result got load=%h err=%b exp load=%h err=1", dmemload, bus_err, c_ERR_WORD);
        end
        dev_stuck = 1'b0; dev_wait = 0;
        imemREN = 1'b1; imemaddr = 32'h10;
        got = -1;
        for (int c = 0; c < 15 && got < 0; c++) begin
            @(negedge CLK);
            if (ihit) got = c;
            step();
        end
        imemREN = 1'b0;
        exp_imemload = ref_read(32'h10);
        checks++;
        if (got !== 2 || imemload !== exp_imemload || bus_err !== 1'b1) begin
            failures++;
            $display("FAIL to_sticky got cyc=%0d load=%h err=%b exp cyc=2 load=%h err=1", got, imemload, bus_err, exp_imemload);
        end
    endtask

    task automatic test_reset_mid_access();
        dev_stuck = 1'b1;
        imemREN = 1'b1; imemaddr = 32'h20;
        step(); @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1) begin failures++; $display("FAIL rm_in_iacc got=%b exp=1", ramREN); end
        #1 nRST = 1'b0;
        #1;
        checks++;
        if ({ramREN, ramWEN, ihit, dhit, halted, bus_err} !== 6'b0) begin
            failures++; $display("FAIL rm_flags got=%b exp=000000", {ramREN, ramWEN, ihit, dhit, halted, bus_err});
        end
        checks++;
        if (imemload !== 32'h0 || dmemload !== 32'h0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            failures++; $display("FAIL rm_data got=%h/%h/%h/%h exp=0", imemload, dmemload, ramaddr, ramstore);
        end
        exp_imemload = 32'h0; exp_dmemload = 32'h0; exp_bus_err = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0) begin failures++; $display("FAIL rm_idle got ren=%b exp=0", ramREN); end
        step(); @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h20) begin
            failures++; $display("FAIL rm_refetch got ren=%b addr=%h exp ren=1 addr=00000020", ramREN, ramaddr);
        end
        step();
        imemREN = 1'b0;
        step();
        dev_stuck = 1'b0;
    endtask

    task automatic test_halt();
        int got;
        bit bad;
        dev_stuck = 1'b0; dev_wait = 1;
        halt = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h44;
        got = -1;
        for (int c = 0; c < 12 && got < 0; c++) begin
            @(negedge CLK);
            if (dhit) got = c;
            step();
        end
        dmemREN = 1'b0;
        exp_dmemload = ref_read(32'h44);
        checks++;
        if (got !== 3 || dmemload !== exp_dmemload) begin
            failures++; $display("FAIL halt_read got cyc=%0d load=%h exp cyc=3 load=%h", got, dmemload, exp_dmemload);
        end
        checks++;
        if (halted !== 1'b0) begin failures++; $display("FAIL halt_early got=%b exp=0", halted); end
        imemREN = 1'b1; imemaddr = 32'h8;
        bad = 1'b0;
        step();
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (ramREN || ramWEN || ihit || dhit || !halted) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin failures++; $display("FAIL halt_ignores got activity=1 exp=0"); end
        checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%b exp=1", halted); end
        idle_inputs();
    endtask

    initial begin
        nRST = 1'b0;
        idle_inputs();
        imemaddr = 32'h0; dmemaddr = 32'h0; dmemstore = 32'h0;
        test_reset();
        test_zero_wait_fetch();
        test_simultaneous();
        test_withdrawal();
        test_random();
        test_timeout();
        test_reset_mid_access();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dp_mem_responder.md
Name: dp_mem_responder

Overview:
- Memory-side responder for the datapath's cache interface.
- Accepts instruction-fetch and data read/write requests and arbitrates them onto a single word-wide RAM port.
- Returns one-cycle ihit/dhit pulses together with registered load data.
- Sits between the datapath and main memory and stands in for the caches.

Parameters:
TIMEOUT, 255, maximum cycles an access waits for ram_ready before forced completion with an error (1..65535)
ERR_WORD, 32'hBAD1BAD1, load value returned on a timed-out read

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
imemREN  input  1  instruction fetch request (level, held until ihit)
imemaddr  input  32  fetch byte address
dmemREN  input  1  data read request (level, held until dhit)
dmemWEN  input  1  data write request (level, held until dhit)
dmemaddr  input  32  data byte address
dmemstore  input  32  write data
halt  input  1  datapath halted
ihit  output  1  one-cycle pulse: fetch complete, imemload valid
imemload  output  32  registered instruction word
dhit  output  1  one-cycle pulse: data access complete, dmemload valid
dmemload  output  32  registered read data
halted  output  1  sticky: responder has stopped servicing requests
bus_err  output  1  sticky: an access timed out
ramREN  output  1  RAM read strobe
ramWEN  output  1  RAM write strobe
ramaddr  output  32  word-aligned RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data, valid while ram_ready
ram_ready  input  1  RAM access complete this cycle

Behaviour:
- Reset is asynchronous active-low, on nRST. While nRST=0 the block is held in reset:
  - state=IDLE; ihit, dhit, halted, bus_err = 0; imemload, dmemload = 0; timeout counter = 0.
  - All ram* outputs = 0.
- The state register is the only source of the RAM strobes; strobes are decoded combinationally from state and the live request.
- States: IDLE, DACC, IACC, DONE, HALT.
- IDLE:
  - If dmemREN|dmemWEN, go to DACC. Data has priority over a simultaneous imemREN.
  - Else if imemREN and !halt, go to IACC.
  - Else if halt, go to HALT.
  - Else stay in IDLE.
  - No RAM strobe is asserted in IDLE.
- DACC:
  - ramREN=dmemREN, ramWEN=dmemWEN, ramaddr={dmemaddr[31:2],2'b00}, ramstore=dmemstore.
  - If dmemREN and dmemWEN are both high, the access is a write: ramREN=0.
- IACC: ramREN=1, ramaddr={imemaddr[31:2],2'b00}, ramWEN=0, ramstore=0.
- Completion in DACC/IACC when ram_ready=1:
  - On a read, latch ramload into dmemload/imemload.
  - Go to DONE; the matching hit is high for exactly the DONE cycle.
  - Writes leave dmemload unchanged.
- Withdrawal: if the active request deasserts in DACC/IACC before ram_ready, go to IDLE the next cycle with no hit. Strobes drop the same cycle, since they are combinational on the request.
- Timeout:
  - The counter is cleared on entry to DACC/IACC and increments each cycle without ram_ready.
  - When the counter reaches TIMEOUT-1 without ram_ready, the access completes as if ram_ready had arrived, and bus_err is set.
  - A read returns ERR_WORD.
  - bus_err stays set until reset.
- DONE: hit pulse high, no strobes; unconditionally go to IDLE. A request still high in the following IDLE cycle is treated as a new request.
- HALT:
  - halted=1 and no strobes; remains in HALT until reset.
  - imemREN is ignored.
  - A data request arriving in the same IDLE cycle as halt is serviced first.
- Latency: request in IDLE at cycle 0; strobe from cycle 1; ram_ready at cycle k gives a hit at cycle k+1.
  - With a zero-wait RAM (ram_ready in cycle 1), the hit is at cycle 2.
- ihit and dhit are never high in the same cycle. Load registers hold their value outside completions.

Test Plan:
- Reset mid-access: nRST low during IACC -> the same cycle, ramREN=0 and all outputs are at reset values; after release, state=IDLE.
- Zero-wait fetch: imemREN=1, imemaddr=0x00000006, ram_ready tied high, ramload=0x3C010004 -> ramaddr=0x00000004 in cycle 1; ihit=1 and imemload=0x3C010004 in cycle 2.
- Simultaneous requests: imemREN=1 and dmemWEN=1 at addr 0x100, data 0xDEADBEEF, 3-cycle RAM:
  - Data first: ramWEN=1, ramstore=0xDEADBEEF, dhit at cycle 5.
  - Then IACC begins in cycle 7 and ihit follows.
- Withdrawal: dmemREN asserted, then dropped after 1 cycle with ram_ready=0 -> ramREN drops the same cycle, no dhit, IDLE next cycle.
- Timeout with TIMEOUT=4 and ram_ready stuck at 0: read at 0x40 -> dhit at cycle 5 with dmemload=0xBAD1BAD1; bus_err=1 and stays 1.
- Halt: halt=1 and dmemREN=1 in IDLE -> the read completes, then HALT with halted=1; subsequent imemREN produces no ramREN and no ihit.
